spike_aer_encoder: RTL and testbench

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

---
 rtl/nn_pkg.sv | 19 +
 rtl/spike_fifo.sv | 49 ++++
 rtl/spike_aer_encoder.sv | 107 ++++++++++
 tb/tb_spike_aer_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared constants, address-width helper and event type for the spike AER encoder.
package nn_pkg;

    localparam int TS_WIDTH_DEF = 16;
    localparam int NUM_COLS_DEF = 4;

    // A single column still needs a 1-bit address field on the bus.
    function automatic int aer_addr_w(input int num_cols);
        return (num_cols > 1) ? $clog2(num_cols) : 1;
    endfunction

    localparam int AER_ADDR_W_DEF = aer_addr_w(NUM_COLS_DEF);

    typedef struct packed {
        logic [AER_ADDR_W_DEF-1:0] addr;
        logic [TS_WIDTH_DEF-1:0]   ts;
    } aer_event_t;

endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: synchronous FIFO with occupancy count; overflowing pushes and
// underflowing pops are ignored.
module spike_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  T                       push_data,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = level == (PW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            level <= level + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible through head while level != 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: latches per-column spikes, round-robin grants one column per
// cycle into a timestamped event FIFO, and presents the head on a valid/ready bus.
module spike_aer_encoder
    import nn_pkg::*;
#(
    parameter int NUM_COLS   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = TS_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            output_spike [NUM_COLS],
    output logic                            aer_valid,
    input  logic                            aer_ready,
    output logic [aer_addr_w(NUM_COLS)-1:0] aer_addr,
    output logic [TS_WIDTH-1:0]             aer_ts,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [7:0]                      drop_count
);

    localparam int AW = aer_addr_w(NUM_COLS);

    typedef struct packed {
        logic [AW-1:0]       addr;
        logic [TS_WIDTH-1:0] ts;
    } col_event_t;

    logic [NUM_COLS-1:0] pending;
    logic [NUM_COLS-1:0] spike_vec;
    logic [NUM_COLS-1:0] grant_vec;
    logic [AW-1:0]       last_grant;
    logic [AW-1:0]       grant_idx;
    logic [AW-1:0]       cand;
    logic                found;
    logic                grant;
    logic                fifo_full;
    logic                fifo_empty;
    logic [TS_WIDTH-1:0] ts_counter;
    logic [7:0]          drop_next;
    int                  drops;
    col_event_t          push_ev;
    col_event_t          head;

    always_comb begin
        spike_vec = '0;
        for (int j = 0; j < NUM_COLS; j++) spike_vec[j] = output_spike[j];
    end

    // Round-robin: first pending column strictly after last_grant, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_COLS; i++) begin
            cand = AW'((int'(last_grant) + i) % NUM_COLS);
            if (!found && pending[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant     = found && !fifo_full;
    assign grant_vec = grant ? (NUM_COLS'(1) << grant_idx) : '0;
    assign push_ev   = '{addr: grant_idx, ts: ts_counter};

    // A spike is lost only when its column is already pending and not being granted.
    always_comb begin
        drops = 0;
        for (int j = 0; j < NUM_COLS; j++) drops += int'(spike_vec[j] && pending[j] && !grant_vec[j]);
        drop_next = (int'(drop_count) + drops > 255) ? 8'd255 : 8'(int'(drop_count) + drops);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            last_grant <= AW'(NUM_COLS - 1);
            ts_counter <= '0;
            drop_count <= '0;
        end else begin
            pending    <= (pending & ~grant_vec) | spike_vec;
            ts_counter <= ts_counter + TS_WIDTH'(1);
            drop_count <= drop_next;
            if (grant) last_grant <= grant_idx;
        end
    end

    spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (col_event_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant),
        .pop       (aer_valid && aer_ready),
        .push_data (push_ev),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign aer_valid = !fifo_empty;
    assign aer_addr  = aer_valid ? head.addr : '0;
    assign aer_ts    = aer_valid ? head.ts : '0;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder: directed scenario tests for spike_aer_encoder (4 columns, depth 8, 16-bit ts).
module tb_spike_aer_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        aer_ready = 1'b0;
    logic        output_spike [4];
    logic        aer_valid;
    logic [1:0]  aer_addr;
    logic [15:0] aer_ts;
    logic [3:0]  fifo_level;
    logic [7:0]  drop_count;
    logic [15:0] ts_m;
    int          errors = 0;
    int          checks = 0;

    spike_aer_encoder #(
        .NUM_COLS   (4),
        .FIFO_DEPTH (8),
        .TS_WIDTH   (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .output_spike (output_spike),
        .aer_valid    (aer_valid),
        .aer_ready    (aer_ready),
        .aer_addr     (aer_addr),
        .aer_ts       (aer_ts),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    // Reference timestamp: counts rising edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) ts_m <= 16'd0;
        else ts_m <= ts_m + 16'd1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_spikes(input logic [3:0] m);
        for (int i = 0; i < 4; i++) output_spike[i] = m[i];
    endtask

    task automatic do_reset;
        @(negedge clk);
        set_spikes(4'b0000);
        aer_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fill_fifo;
        set_spikes(4'b1111); tick(); set_spikes(4'b0000); tick(5);
        set_spikes(4'b1111); tick(); set_spikes(4'b0000); tick(5);
    endtask

    task automatic test_reset;
        set_spikes(4'b0000);
        #2 reset = 1'b0;
        #1;
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", aer_valid); end
        checks++; if (aer_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", aer_addr); end
        checks++; if (aer_ts !== 16'd0) begin errors++; $display("FAIL reset_ts: got %h want 0000", aer_ts); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        tick(2);
        reset = 1'b1;
    endtask

    task automatic test_single;
        aer_ready = 1'b1;
        for (int i = 0; i < 100 && ts_m != 16'd5; i++) tick();
        set_spikes(4'b0100);
        tick();
        set_spikes(4'b0000);
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL single_latency: valid got %b want 0", aer_valid); end
        tick();
        checks++; if (aer_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", aer_valid); end
        checks++; if (aer_addr !== 2'd2) begin errors++; $display("FAIL single_addr: got %0d want 2", aer_addr); end
        checks++; if (aer_ts !== 16'd6) begin errors++; $display("FAIL single_ts: got %0d want 6", aer_ts); end
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", fifo_level); end
        tick();
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL single_after: valid got %b want 0", aer_valid); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp3 [3] = '{2'd0, 2'd1, 2'd3};
        logic [1:0] exp4 [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        do_reset();
        aer_ready = 1'b1;
        set_spikes(4'b1011); tick(); set_spikes(4'b0000); tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (aer_valid !== 1'b1 || aer_addr !== exp3[i]) begin errors++; $display("FAIL rr3_%0d: valid=%b addr=%0d want valid=1 addr=%0d", i, aer_valid, aer_addr, exp3[i]); end
            tick();
        end
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL rr3_end: valid got %b want 0", aer_valid); end
        set_spikes(4'b1111); tick(); set_spikes(4'b0000); tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (aer_valid !== 1'b1 || aer_addr !== exp4[i]) begin errors++; $display("FAIL rr4_%0d: valid=%b addr=%0d want valid=1 addr=%0d", i, aer_valid, aer_addr, exp4[i]); end
            tick();
        end
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL rr4_end: valid got %b want 0", aer_valid); end
    endtask

    task automatic test_collision;
        do_reset();
        aer_ready = 1'b1;
        set_spikes(4'b0100); tick(2); set_spikes(4'b0000);
        checks++; if (aer_valid !== 1'b1 || aer_addr !== 2'd2) begin errors++; $display("FAIL coll_first: valid=%b addr=%0d want 1/2", aer_valid, aer_addr); end
        tick();
        checks++; if (aer_valid !== 1'b1 || aer_addr !== 2'd2) begin errors++; $display("FAIL coll_second: valid=%b addr=%0d want 1/2", aer_valid, aer_addr); end
        tick();
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL coll_end: valid got %b want 0", aer_valid); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL coll_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_backpressure;
        logic [1:0] exp [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        fill_fifo();
        set_spikes(4'b0011); tick(); set_spikes(4'b0000); tick(3);
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL bp_level: got %0d want 8", fifo_level); end
        checks++; if (aer_valid !== 1'b1 || aer_addr !== 2'd0) begin errors++; $display("FAIL bp_head_stable: valid=%b addr=%0d want 1/0", aer_valid, aer_addr); end
        aer_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (aer_valid !== 1'b1 || aer_addr !== exp[i]) begin errors++; $display("FAIL bp_ev%0d: valid=%b addr=%0d want valid=1 addr=%0d", i, aer_valid, aer_addr, exp[i]); end
            tick();
        end
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL bp_end: valid got %b want 0", aer_valid); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL bp_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_drops;
        do_reset();
        fill_fifo();
        set_spikes(4'b0010); tick(3); set_spikes(4'b0000);
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL drop_two: got %0d want 2", drop_count); end
        set_spikes(4'b0010); tick(300); set_spikes(4'b0000); tick();
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", drop_count); end
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL drop_level: got %0d want 8", fifo_level); end
    endtask

    task automatic test_mid_reset;
        do_reset();
        set_spikes(4'b1111); tick(); set_spikes(4'b0000); tick(5);
        set_spikes(4'b0001); tick(); set_spikes(4'b0000); tick(2);
        checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL mr_level_before: got %0d want 5", fifo_level); end
        set_spikes(4'b0100); tick(); set_spikes(4'b0000);
        #2 reset = 1'b0;
        #1;
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL mr_valid_async: got %b want 0", aer_valid); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL mr_level_async: got %0d want 0", fifo_level); end
        checks++; if (aer_addr !== 2'd0 || aer_ts !== 16'd0) begin errors++; $display("FAIL mr_bus_async: addr=%0d ts=%h want 0/0000", aer_addr, aer_ts); end
        tick();
        reset = 1'b1;
        aer_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL mr_stale%0d: valid got %b want 0 (addr=%0d)", i, aer_valid, aer_addr); end
        end
    endtask

    task automatic test_wrap;
        do_reset();
        aer_ready = 1'b1;
        for (int i = 0; i < 70000 && ts_m != 16'hFFFE; i++) tick();
        checks++; if (ts_m !== 16'hFFFE) begin errors++; $display("FAIL wrap_reach: ts model got %h want fffe", ts_m); end
        set_spikes(4'b0001); tick();
        set_spikes(4'b0010); tick();
        set_spikes(4'b0000);
        checks++; if (aer_valid !== 1'b1 || aer_addr !== 2'd0 || aer_ts !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: valid=%b addr=%0d ts=%h want 1/0/ffff", aer_valid, aer_addr, aer_ts); end
        tick();
        checks++; if (aer_valid !== 1'b1 || aer_addr !== 2'd1 || aer_ts !== 16'h0000) begin errors++; $display("FAIL wrap_0000: valid=%b addr=%0d ts=%h want 1/1/0000", aer_valid, aer_addr, aer_ts); end
        tick();
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL wrap_end: valid got %b want 0", aer_valid); end
    endtask

    initial begin
        set_spikes(4'b0000);
        test_reset();
        test_single();
        test_round_robin();
        test_collision();
        test_backpressure();
        test_drops();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
